// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
package program_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned COUNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        COUNT_LO,
        COUNT_HI,
        PAYLOAD,
        CHECKSUM,
        ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/program_loader_uart_byte_receiver.sv
// 8N1 UART byte receiver: synchronizes rx, validates the start bit at mid-bit,
// samples data LSB first and reports each byte or a framing error as a one-cycle pulse.
module uart_byte_receiver
    import program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_error
);

    localparam int unsigned CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF_CNT = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_CNT = CLKS_PER_BIT - 1;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_meta, rx_sync, rx_prev;
    logic             byte_valid_d, framing_error_d;
    logic [7:0]       byte_data_d;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RX_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_valid    <= 1'b0;
            byte_data     <= '0;
            framing_error <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_valid    <= byte_valid_d;
            byte_data     <= byte_data_d;
            framing_error <= framing_error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + CNT_W'(1);
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        byte_valid_d    = 1'b0;
        byte_data_d     = byte_data;
        framing_error_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_sync) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF_CNT)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(FULL_CNT)) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(FULL_CNT)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        framing_error_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// Serial boot loader: parses sync/count/payload/checksum frames from the UART,
// writes 32-bit words to program memory and holds the core until a verified image.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              mem_write_enable,
    output logic [WORD_W-1:0] mem_write_address,
    output logic [WORD_W-1:0] mem_write_data,
    output logic              processor_hold,
    output logic              load_done,
    output logic              load_error
);

    logic       rx_byte_valid, rx_framing_error;
    logic [7:0] rx_byte;

    uart_byte_receiver #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (uart_rx),
        .byte_valid    (rx_byte_valid),
        .byte_data     (rx_byte),
        .framing_error (rx_framing_error)
    );

    loader_state_e      state_q, state_d;
    logic [7:0]         count_lo_q, count_lo_d;
    logic [COUNT_W-1:0] words_left_q, words_left_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [WORD_W-1:0]  addr_q, addr_d;
    logic [7:0]         xor_q, xor_d;
    logic               we_d, hold_d, done_d, err_d;
    logic [WORD_W-1:0]  wa_d, wd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            count_lo_q        <= '0;
            words_left_q      <= '0;
            byte_idx_q        <= '0;
            word_q            <= '0;
            addr_q            <= BASE_ADDRESS;
            xor_q             <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            processor_hold    <= 1'b0;
            load_done         <= 1'b0;
            load_error        <= 1'b0;
        end else begin
            state_q           <= state_d;
            count_lo_q        <= count_lo_d;
            words_left_q      <= words_left_d;
            byte_idx_q        <= byte_idx_d;
            word_q            <= word_d;
            addr_q            <= addr_d;
            xor_q             <= xor_d;
            mem_write_enable  <= we_d;
            mem_write_address <= wa_d;
            mem_write_data    <= wd_d;
            processor_hold    <= hold_d;
            load_done         <= done_d;
            load_error        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_lo_d   = count_lo_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        addr_d       = addr_q;
        xor_d        = xor_q;
        we_d         = 1'b0;
        wa_d         = mem_write_address;
        wd_d         = mem_write_data;
        hold_d       = processor_hold;
        done_d       = 1'b0;
        err_d        = load_error;
        // ERROR already carries the sticky flag, so it ignores framing errors like IDLE
        if (rx_framing_error && state_q != IDLE && state_q != ERROR) begin
            err_d   = 1'b1;
            state_d = ERROR;
        end else if (rx_byte_valid) begin
            case (state_q)
                IDLE, ERROR: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = COUNT_LO;
                        err_d   = 1'b0;
                        hold_d  = 1'b1;
                    end
                end
                COUNT_LO: begin
                    count_lo_d = rx_byte;
                    xor_d      = '0;
                    byte_idx_d = '0;
                    addr_d     = BASE_ADDRESS;
                    state_d    = COUNT_HI;
                end
                COUNT_HI: begin
                    words_left_d = {rx_byte, count_lo_q};
                    xor_d        = '0;
                    byte_idx_d   = '0;
                    addr_d       = BASE_ADDRESS;
                    state_d      = ({rx_byte, count_lo_q} == '0) ? CHECKSUM : PAYLOAD;
                end
                PAYLOAD: begin
                    xor_d = xor_q ^ rx_byte;
                    word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d         = 1'b1;
                        wa_d         = addr_q;
                        wd_d         = {rx_byte, word_q[23:0]};
                        addr_d       = addr_q + 32'd4;
                        words_left_d = words_left_q - COUNT_W'(1);
                        if (words_left_q == COUNT_W'(1)) state_d = CHECKSUM;
                    end
                end
                CHECKSUM: begin
                    if (rx_byte == xor_q) begin
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
